// File: rtl/conv_pkg.sv
// conv_pkg: constants and small helpers shared by the conv ReLU/max-pool
// collector and its result FIFO.
//   - Register offsets from the device base address.
//   - Bit positions of the status word.
//   - Bit positions of the CFG register.
//   - fp32 helpers:
//     - relu_fp32 clamps any value with the sign bit set to +0.
//     - max_u32 is an unsigned compare. It only works as an fp32 max
//       because both operands are already non-negative after ReLU.
package conv_pkg;

  localparam logic [31:0] OFS_DATA = 32'h0;
  localparam logic [31:0] OFS_STAT = 32'h4;
  localparam logic [31:0] OFS_CFG  = 32'h8;

  localparam int STAT_OVF_BIT    = 31;
  localparam int STAT_EMPTY_BIT  = 30;
  localparam int STAT_FULL_BIT   = 29;
  localparam int STAT_ROWPAR_BIT = 16;
  localparam int STAT_COUNT_W    = 8;

  localparam int CFG_CLR_BIT = 31;
  localparam int CFG_W_BITS  = 6;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_DATA,
    SEL_STAT,
    SEL_CFG,
    SEL_NONE
  } reg_sel_t;

  // Any sign-bit-set input (negatives, -0, negative NaN) becomes +0.
  function automatic logic [31:0] relu_fp32(input logic [31:0] x);
    return x[31] ? FP32_ZERO : x;
  endfunction

  // For non-negative IEEE-754 values the bit pattern orders like an unsigned int.
  function automatic logic [31:0] max_u32(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pooled_fifo.sv
// pooled_fifo: synchronous FIFO holding the pooled results.
//   clk_i   clock
//   rst_i   synchronous reset, active low
//   clr_i   synchronous clear (empties the FIFO)
//   push_i  write request
//   din_i   write data
//   pop_i   read request
//   dout_o  head entry (combinational from the storage array)
//   count_o number of stored entries
//   full_o  the FIFO holds DEPTH entries
//   empty_o the FIFO holds no entries
//   drop_o  a push was refused because the FIFO was full
// Pop and push rules:
//   - A pop while empty is ignored.
//   - A push while full is accepted only when a real pop frees a slot in the
//     same cycle. Otherwise the push is dropped and drop_o is raised.
module pooled_fifo
  import conv_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [DW-1:0]            din_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_reg == '0);
  assign full_o  = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~do_push;
  assign count_o = count_reg;
  assign dout_o  = mem[rd_ptr_reg];

  always_ff @(posedge clk_i) begin
    if (!rst_i || clr_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // The storage array is not reset. Only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_reg] <= din_i;
  end

endmodule

// File: rtl/conv_relu_maxpool_collector.sv
// conv_relu_maxpool_collector: takes raster-order fp32 conv outputs and
// processes them as follows:
//   1. Applies ReLU.
//   2. Max-pools 2x2 windows with stride 2.
//   3. Queues each pooled value for the CPU to read.
// Ports:
//   clk_i        clock
//   rst_i        synchronous reset, active low
//   res_valid_i  conv result valid, one per cycle, no backpressure
//   res_data_i   fp32 conv result
//   en_i         bus access strobe
//   we_i         1 = write, 0 = read
//   addr_i       byte address
//   data_i       write data
//   ready_o      access done (one cycle after en_i)
//   data_o       registered read data
// Register map (offsets from BASE_ADDR):
//   +0x0 R   pop FIFO head
//   +0x4 R   status
//   +0x8 RW  CFG / W
module conv_relu_maxpool_collector
  import conv_pkg::*;
#(
  parameter int               XLEN       = 32,
  parameter int               MAX_W      = 24,
  parameter int               FIFO_DEPTH = 16,
  parameter logic [XLEN-1:0]  BASE_ADDR  = 32'hC440_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            res_valid_i,
  input  logic [XLEN-1:0] res_data_i,
  input  logic            en_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] data_i,
  output logic            ready_o,
  output logic [XLEN-1:0] data_o
);

  localparam int LBUF_N = MAX_W / 2;
  localparam int LW     = $clog2(LBUF_N);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CFG_W_BITS-1:0] MAX_W_L = CFG_W_BITS'(MAX_W);

  // Window state
  logic [CFG_W_BITS-1:0] w_reg;
  logic [CFG_W_BITS-1:0] col_reg;
  logic                  row_par_reg;
  logic                  ovf_reg;
  logic [31:0]           hreg_reg;
  // The line buffer holds one horizontal max per window of the even row.
  logic [31:0]           lbuf [LBUF_N];

  // Bus decode
  reg_sel_t              sel;
  logic                  cfg_wr;
  logic                  clr;
  logic                  w_wr;
  logic [CFG_W_BITS-1:0] w_new;
  logic                  w_valid;
  logic                  take;
  logic                  rd_en;
  logic [XLEN-1:0]       rd_mux;
  logic [XLEN-1:0]       stat;

  // Datapath
  logic [31:0]           relu_r;
  logic [31:0]           h;
  logic [31:0]           pooled;
  logic [LW-1:0]         lidx;
  logic                  col_last;

  // FIFO
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [31:0]           fifo_dout;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_drop;

  // Write-data bits that CFG ignores
  logic                  unused_bits;
  assign unused_bits = ^data_i[XLEN-2:CFG_W_BITS];

  always_comb begin
    sel = SEL_NONE;
    if (addr_i == BASE_ADDR + OFS_DATA)      sel = SEL_DATA;
    else if (addr_i == BASE_ADDR + OFS_STAT) sel = SEL_STAT;
    else if (addr_i == BASE_ADDR + OFS_CFG)  sel = SEL_CFG;
  end

  assign cfg_wr  = en_i & we_i & (sel == SEL_CFG);
  assign clr     = cfg_wr & data_i[CFG_CLR_BIT];
  assign w_new   = data_i[CFG_W_BITS-1:0];
  assign w_valid = ~w_new[0] & (w_new >= 6'd2) & (w_new <= MAX_W_L);
  assign w_wr    = cfg_wr & ~data_i[CFG_CLR_BIT] & w_valid;
  // A clear or an accepted W write resets the window position.
  // Any sample arriving in the same cycle is therefore discarded.
  assign take    = res_valid_i & ~(clr | w_wr);

  assign rd_en    = en_i & ~we_i;
  assign fifo_pop = rd_en & (sel == SEL_DATA);

  assign relu_r   = relu_fp32(res_data_i);
  assign lidx     = col_reg[LW:1];
  assign h        = max_u32(hreg_reg, relu_r);
  assign pooled   = max_u32(lbuf[lidx], h);
  assign col_last = (col_reg == w_reg - 6'd1);

  // A window completes on the odd column of the odd row.
  assign fifo_push = take & col_reg[0] & row_par_reg;

  pooled_fifo #(
    .DW    (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr),
    .push_i  (fifo_push),
    .din_i   (pooled),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  always_comb begin
    stat                                = '0;
    stat[STAT_OVF_BIT]                  = ovf_reg;
    stat[STAT_EMPTY_BIT]                = fifo_empty;
    stat[STAT_FULL_BIT]                 = fifo_full;
    stat[STAT_ROWPAR_BIT]               = row_par_reg;
    stat[STAT_COUNT_W-1:0]              = STAT_COUNT_W'(fifo_count);
  end

  always_comb begin
    rd_mux = '0;
    case (sel)
      SEL_DATA: rd_mux = fifo_empty ? FP32_ZERO : fifo_dout;
      SEL_STAT: rd_mux = stat;
      SEL_CFG:  rd_mux = {{(XLEN-CFG_W_BITS){1'b0}}, w_reg};
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ready_o     <= 1'b0;
      data_o      <= '0;
      w_reg       <= MAX_W_L;
      col_reg     <= '0;
      row_par_reg <= 1'b0;
      ovf_reg     <= 1'b0;
      hreg_reg    <= '0;
    end else begin
      ready_o <= en_i;
      data_o  <= rd_en ? rd_mux : '0;

      if (clr) begin
        col_reg     <= '0;
        row_par_reg <= 1'b0;
      end else if (w_wr) begin
        w_reg       <= w_new;
        col_reg     <= '0;
        row_par_reg <= 1'b0;
      end else if (take) begin
        if (!col_reg[0]) hreg_reg <= relu_r;
        if (col_last) begin
          col_reg     <= '0;
          row_par_reg <= ~row_par_reg;
        end else begin
          col_reg <= col_reg + 6'd1;
        end
      end

      if (clr)            ovf_reg <= 1'b0;
      else if (fifo_drop) ovf_reg <= 1'b1;
    end
  end

  // The line buffer is not reset.
  // Each slot is written on the even row before the odd row reads it.
  always_ff @(posedge clk_i) begin
    if (take && col_reg[0] && !row_par_reg) lbuf[lidx] <= h;
  end

endmodule

// File: tb/tb_conv_relu_maxpool_collector.sv
module tb_conv_relu_maxpool_collector;

  localparam logic [31:0] BASE = 32'hC440_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic [31:0] res_data;
  logic        en;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  // Scoreboard: pooled values the DUT FIFO should hold, oldest first.
  logic [31:0] exp_q[$];
  int          m_w   = 24;
  int          m_col = 0;
  bit          m_rp  = 1'b0;
  bit          m_ovf = 1'b0;
  logic [31:0] m_h   = 32'h0;
  logic [31:0] m_lb [12];

  conv_relu_maxpool_collector dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .res_valid_i (res_valid),
    .res_data_i  (res_data),
    .en_i        (en),
    .we_i        (we),
    .addr_i      (addr),
    .data_i      (wdata),
    .ready_o     (ready),
    .data_o      (rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic m_push(input logic [31:0] p);
    if (exp_q.size() < 16) exp_q.push_back(p);
    else m_ovf = 1'b1;
  endtask

  task automatic m_feed(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] hm;
    r = v[31] ? 32'h0 : v;
    if (m_col % 2 == 0) begin
      m_h = r;
    end else begin
      hm = (m_h > r) ? m_h : r;
      if (!m_rp) m_lb[m_col/2] = hm;
      else m_push((m_lb[m_col/2] > hm) ? m_lb[m_col/2] : hm);
    end
    if (m_col == m_w - 1) begin
      m_col = 0;
      m_rp  = ~m_rp;
    end else begin
      m_col++;
    end
  endtask

  function automatic logic [31:0] exp_stat();
    logic [31:0] s;
    s       = 32'h0;
    s[31]   = m_ovf;
    s[30]   = (exp_q.size() == 0);
    s[29]   = (exp_q.size() == 16);
    s[16]   = m_rp;
    s[7:0]  = 8'(exp_q.size());
    return s;
  endfunction

  task automatic feed(input logic [31:0] v);
    res_valid = 1'b1;
    res_data  = v;
    m_feed(v);
    cyc();
    res_valid = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] ofs, input logic [31:0] v);
    en = 1'b1; we = 1'b1; addr = BASE + ofs; wdata = v;
    if (ofs == 32'h8) begin
      if (v[31]) begin
        m_col = 0; m_rp = 1'b0; m_ovf = 1'b0;
        exp_q.delete();
      end else if (!v[0] && v[5:0] >= 6'd2 && v[5:0] <= 6'd24) begin
        m_w = int'(v[5:0]); m_col = 0; m_rp = 1'b0;
      end
    end
    cyc();
    $display("wr ofs=%0h data=%08h", ofs, v);
    check("wr_ready", {31'h0, ready}, 32'h1);
    en = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] ofs, output logic [31:0] d);
    en = 1'b1; we = 1'b0; addr = BASE + ofs;
    cyc();
    d = rdata;
    $display("rd ofs=%0h data=%08h", ofs, d);
    check("rd_ready", {31'h0, ready}, 32'h1);
    en = 1'b0;
  endtask

  task automatic rd_stat(input string tag);
    logic [31:0] e;
    logic [31:0] d;
    e = exp_stat();
    bus_rd(32'h4, d);
    check(tag, d, e);
  endtask

  task automatic rd_pop(input string tag);
    logic [31:0] e;
    logic [31:0] d;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h0;
    bus_rd(32'h0, d);
    check(tag, d, e);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] e;
    rst = 1'b0; en = 1'b0; we = 1'b0; res_valid = 1'b0;
    res_data = 32'h0; addr = 32'h0; wdata = 32'h0;

    // T1 reset
    cyc(); cyc();
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_data", rdata, 32'h0);
    rst = 1'b1;
    cyc();
    check("idle_ready", {31'h0, ready}, 32'h0);
    bus_rd(32'h4, d);
    check("t1_stat", d, 32'h4000_0000);
    bus_rd(32'h8, d);
    check("t1_w", d, 32'd24);
    cyc();
    check("idle_ready2", {31'h0, ready}, 32'h0);

    // Unmapped access
    bus_rd(32'h10, d);
    check("unmapped_rd", d, 32'h0);

    // T2 pool, W=4; an odd W must be rejected
    bus_wr(32'h8, 32'd4);
    bus_wr(32'h8, 32'd3);
    bus_rd(32'h8, d);
    check("t2_w", d, 32'd4);
    feed(32'h3F80_0000); feed(32'h4000_0000); feed(32'h4040_0000); feed(32'h3F00_0000);
    feed(32'h4080_0000); feed(32'hBF80_0000); feed(32'h0000_0000); feed(32'h40A0_0000);
    rd_stat("t2_stat");
    rd_pop("t2_pop0");
    rd_pop("t2_pop1");
    rd_pop("t2_pop_empty");
    rd_stat("t2_stat_empty");

    // T3 ReLU on an all-negative window
    bus_wr(32'h8, 32'd2);
    feed(32'hBF80_0000); feed(32'hC000_0000); feed(32'h8000_0000); feed(32'hFF80_0000);
    rd_stat("t3_stat");
    rd_pop("t3_pop");

    // T4 overflow: 17 windows, no reads
    for (int k = 0; k < 17; k++)
      for (int i = 1; i <= 4; i++) feed(32'h0100_0000 + 32'(k * 16 + i));
    rd_stat("t4_stat");
    for (int k = 0; k < 16; k++) rd_pop($sformatf("t4_pop%0d", k));
    rd_stat("t4_stat_drained");

    // T5 full FIFO: pop and window-completing push in the same cycle
    bus_wr(32'h8, 32'h8000_0000);
    rd_stat("t5_stat_clr");
    for (int k = 0; k < 16; k++)
      for (int i = 1; i <= 4; i++) feed(32'h0200_0000 + 32'(k * 16 + i));
    rd_stat("t5_stat_full");
    feed(32'h0300_0001); feed(32'h0300_0002); feed(32'h0300_0003);
    e = exp_q.pop_front();
    res_valid = 1'b1; res_data = 32'h0300_0004; m_feed(32'h0300_0004);
    en = 1'b1; we = 1'b0; addr = BASE;
    cyc();
    $display("rd ofs=0 data=%08h (with push)", rdata);
    check("t5_ready", {31'h0, ready}, 32'h1);
    check("t5_pop_push", rdata, e);
    res_valid = 1'b0; en = 1'b0;
    rd_stat("t5_stat_after");
    for (int k = 0; k < 16; k++) rd_pop($sformatf("t5_pop%0d", k));

    // T6 clear mid-window, clear colliding with a sample
    bus_wr(32'h8, 32'd4);
    feed(32'h7F00_0000); feed(32'h7E00_0000); feed(32'h7D00_0000);
    res_valid = 1'b1; res_data = 32'h7F7F_FFFF;
    bus_wr(32'h8, 32'h8000_0000);
    res_valid = 1'b0;
    feed(32'h3F80_0000); feed(32'h4000_0000); feed(32'h4040_0000); feed(32'h4080_0000);
    feed(32'h40A0_0000); feed(32'h3F00_0000);
    rd_stat("t6_stat");
    rd_pop("t6_pop");
    bus_rd(32'h8, d);
    check("t6_w_kept", d, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
